// File: rtl/mem_store_buffer.sv
// Store buffer for the MIPS MEM stage: encodes sb/sh/sw into word address,
// replicated data and byte enables, queues them and drains over req/ack.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_size,
  output logic             st_err,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_be,
  output logic             ld_conflict,
  input  logic             fence,
  output logic             fence_done,
  output logic [PTR_W:0]   count
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, offs;
  logic [PTR_W:0]       count_q, count_d, remain;
  logic [29:0]          ent_addr_q  [DEPTH];
  logic [29:0]          ent_addr_d  [DEPTH];
  logic [31:0]          ent_wdata_q [DEPTH];
  logic [31:0]          ent_wdata_d [DEPTH];
  logic [3:0]           ent_be_q    [DEPTH];
  logic [3:0]           ent_be_d    [DEPTH];
  logic [31:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic                 st_err_q, st_err_d;
  logic [3:0]           enc_be;
  logic [31:0]          enc_wdata;
  logic                 enc_legal, accept, push, pop;
  logic                 unused_ld_low;

  assign unused_ld_low = ^ld_addr[1:0];

  always_comb begin
    enc_be    = 4'b0000;
    enc_wdata = 32'h0;
    enc_legal = 1'b0;
    case (st_size)
      2'b00: begin
        enc_be    = 4'b0001 << st_addr[1:0];
        enc_wdata = {4{st_data[7:0]}};
        enc_legal = 1'b1;
      end
      2'b01: begin
        enc_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        enc_wdata = {2{st_data[15:0]}};
        enc_legal = ~st_addr[0];
      end
      2'b10: begin
        enc_be    = 4'b1111;
        enc_wdata = st_data;
        enc_legal = (st_addr[1:0] == 2'b00);
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // No bypass: a full buffer stays not-ready even while popping.
  assign st_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && enc_legal;
  assign pop      = mem_req && mem_ack;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push)
      count_d = count_q - (PTR_W+1)'(1);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    remain   = count_q - (PTR_W+1)'(pop);
    st_err_d = accept && !enc_legal;

    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_d[i]  = ent_addr_q[i];
      ent_wdata_d[i] = ent_wdata_q[i];
      ent_be_d[i]    = ent_be_q[i];
    end
    if (push) begin
      ent_addr_d[wr_ptr_q]  = st_addr[31:2];
      ent_wdata_d[wr_ptr_q] = enc_wdata;
      ent_be_d[wr_ptr_q]    = enc_be;
    end

    // Head registers hold their last value when the buffer drains empty.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (count_d != '0) begin
      if (remain == '0) begin
        mem_addr_d  = {st_addr[31:2], 2'b00};
        mem_wdata_d = enc_wdata;
        mem_be_d    = enc_be;
      end else begin
        mem_addr_d  = {ent_addr_q[rd_ptr_d], 2'b00};
        mem_wdata_d = ent_wdata_q[rd_ptr_d];
        mem_be_d    = ent_be_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req = 1'b1;
        if (count_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entries being popped still conflict; the entry being pushed does not.
  always_comb begin
    ld_conflict = 1'b0;
    offs        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && (ent_addr_q[i] == ld_addr[31:2]) &&
          |(ent_be_q[i] & ld_be))
        ld_conflict = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      st_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      st_err_q    <= st_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_q[i]  <= ent_addr_d[i];
      ent_wdata_q[i] <= ent_wdata_d[i];
      ent_be_q[i]    <= ent_be_d[i];
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign st_err     = st_err_q;
  assign count      = count_q;
  assign fence_done = fence && (count_q == '0);

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a FIFO scoreboard of expected
// memory writes and a reference count/error model updated every cycle.
module tb_mem_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, st_valid, st_ready, st_err, mem_req, mem_ack;
  logic [31:0]      st_addr, st_data, mem_addr, mem_wdata, ld_addr;
  logic [1:0]       st_size;
  logic [3:0]       mem_be, ld_be;
  logic             ld_conflict, fence, fence_done;
  logic [PTR_W:0]   count;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   cnt_model = 0;
  logic err_exp = 1'b0;

  mem_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_err(st_err),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_conflict(ld_conflict), .fence(fence), .fence_done(fence_done),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic encode(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] sz, output exp_t e);
    logic ok;
    e.addr = {a[31:2], 2'b00};
    case (sz)
      2'b00:   begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{d[7:0]}}; ok = 1'b1; end
      2'b01:   begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{d[15:0]}}; ok = !a[0]; end
      2'b10:   begin e.be = 4'b1111; e.wdata = d; ok = (a[1:0] == 2'b00); end
      default: begin e.be = 4'b0000; e.wdata = 32'h0; ok = 1'b0; end
    endcase
    return ok;
  endfunction

  // One clock: update the model from the inputs about to be sampled, then
  // check the DUT just after the edge.
  task automatic tick();
    exp_t e, h;
    logic full, ok;
    if (reset) begin
      sb.delete();
      err_exp = 1'b0;
    end else begin
      full = (sb.size() == DEPTH);
      if (mem_ack && sb.size() != 0) begin
        h = sb.pop_front();
        chk("handshake_head", {mem_addr, mem_wdata, mem_be}, h);
      end
      ok = encode(st_addr, st_data, st_size, e);
      err_exp = st_valid && !full && !ok;
      if (st_valid && !full && ok) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cnt_model = sb.size();
    chk("count", 68'(count), 68'(cnt_model));
    chk("st_ready", 68'(st_ready), 68'(cnt_model != DEPTH));
    chk("mem_req", 68'(mem_req), 68'(cnt_model != 0));
    chk("st_err", 68'(st_err), 68'(err_exp));
    if (sb.size() != 0)
      chk("head_fields", {mem_addr, mem_wdata, mem_be}, sb[0]);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_ack = 1'b0; ld_addr = '0; ld_be = '0; fence = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mem_addr", 68'(mem_addr), 68'h0);
    chk("rst_mem_wdata", 68'(mem_wdata), 68'h0);
    chk("rst_mem_be", 68'(mem_be), 68'h0);

    // sb with ack held high: ack is ignored while mem_req is low
    mem_ack = 1'b1;
    drive(32'h1003, 32'h0000_00AB, 2'b00);
    tick();
    st_valid = 1'b0;
    chk("sb_addr", 68'(mem_addr), 68'h1000);
    chk("sb_be", 68'(mem_be), 68'b1000);
    chk("sb_wdata", 68'(mem_wdata), 68'hABAB_ABAB);
    tick();
    chk("sb_drained", 68'(count), 68'd0);

    drive(32'h2002, 32'h1234_BEEF, 2'b01);
    tick();
    chk("sh_be", 68'(mem_be), 68'b1100);
    chk("sh_wdata", 68'(mem_wdata), 68'hBEEF_BEEF);
    drive(32'h2001, 32'h1234_BEEF, 2'b01);
    tick();
    chk("sh_mis_err", 68'(st_err), 68'd1);
    st_valid = 1'b0;
    tick();
    chk("sh_mis_err_clear", 68'(st_err), 68'd0);
    drive(32'h2000, 32'h0, 2'b11);
    tick();
    drive(32'h2002, 32'h0, 2'b10);
    tick();
    chk("b2b_err", 68'(st_err), 68'd1);
    st_valid = 1'b0;
    tick();

    // Fill, stall, single pop, then sustained push+pop across pointer wrap
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10);
      tick();
    end
    chk("full_ready", 68'(st_ready), 68'd0);
    drive(32'h20, 32'hA000_0004, 2'b10);
    tick();
    chk("full_stall_count", 68'(count), 68'd4);
    mem_ack = 1'b1;
    tick();
    chk("pop_no_bypass", 68'(count), 68'd3);
    mem_ack = 1'b0;
    tick();
    st_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    chk("two_left", 68'(count), 68'd2);
    for (int i = 0; i < 10; i++) begin
      drive(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'b10);
      tick();
      chk("pushpop_count", 68'(count), 68'd2);
    end
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_drained", 68'(count), 68'd0);

    // Load/store overlap
    mem_ack = 1'b0;
    drive(32'h3001, 32'h55, 2'b00);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h3000; ld_be = 4'b0001; #1;
    chk("ldc_no_overlap", 68'(ld_conflict), 68'd0);
    ld_be = 4'b0011; #1;
    chk("ldc_overlap", 68'(ld_conflict), 68'd1);
    ld_addr = 32'h3004; #1;
    chk("ldc_other_word", 68'(ld_conflict), 68'd0);
    drive(32'h4000, 32'h77, 2'b10);
    ld_addr = 32'h4000; ld_be = 4'b1111; #1;
    chk("ldc_push_excluded", 68'(ld_conflict), 68'd0);
    tick();
    st_valid = 1'b0;
    chk("ldc_after_push", 68'(ld_conflict), 68'd1);
    ld_addr = 32'h3000; ld_be = 4'b0010; mem_ack = 1'b1; #1;
    chk("ldc_popping_counts", 68'(ld_conflict), 68'd1);
    tick();
    chk("ldc_after_pop", 68'(ld_conflict), 68'd0);
    tick();

    // Fence with ack every other cycle
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4 * i), 32'hF00D_0000 + 32'(i), 2'b10);
      tick();
    end
    st_valid = 1'b0;
    fence = 1'b1; #1;
    chk("fence_busy", 68'(fence_done), 68'd0);
    for (int i = 0; i < 8; i++) begin
      mem_ack = (i % 2 == 1);
      tick();
      chk("fence_done", 68'(fence_done), 68'(cnt_model == 0));
    end
    chk("fence_final", 68'(fence_done), 68'd1);
    fence = 1'b0;

    // Reset mid-drain with ack asserted
    mem_ack = 1'b0;
    drive(32'h600, 32'h1, 2'b10);
    tick();
    drive(32'h604, 32'h2, 2'b10);
    tick();
    st_valid = 1'b0;
    mem_ack = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_count", 68'(count), 68'd0);
    chk("rst_mid_req", 68'(mem_req), 68'd0);
    chk("rst_mid_addr", 68'(mem_addr), 68'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
